// File: rtl/tt_ascii_instrn_trace_if.sv
// ----------------------------------------------------------------------------
// tt_ascii_instrn_trace_if
//
// Purpose:
//   Trace-sink handshake bundle for tt_ascii_instrn_trace. It carries the FIFO
//   head record toward the sink and the sink's ready back to the buffer. The
//   signal names keep the buffer-side direction prefix, so the names read the
//   same inside the buffer and at the sink.
//
// Signals:
//   o_trace_vld     head record valid            (buffer -> sink)
//   i_trace_rdy     sink accepts the head        (sink   -> buffer)
//   o_trace_ascii   head mnemonic, right-justified, unused upper bytes 0x00
//   o_trace_instrn  head raw 32-bit instruction
//   o_trace_pc      head PC (XLEN bits)
//   o_trace_seq     head sequence number (SEQ_W bits)
//
// Modports:
//   master  the trace buffer (drives the record, samples ready)
//   slave   the trace sink   (samples the record, drives ready)
// ----------------------------------------------------------------------------
interface tt_ascii_instrn_trace_if #(
    parameter int XLEN  = 32,
    parameter int SEQ_W = 16
);

    logic             o_trace_vld;
    logic             i_trace_rdy;
    logic [63:0]      o_trace_ascii;
    logic [31:0]      o_trace_instrn;
    logic [XLEN-1:0]  o_trace_pc;
    logic [SEQ_W-1:0] o_trace_seq;

    modport master (
        output o_trace_vld,
        output o_trace_ascii,
        output o_trace_instrn,
        output o_trace_pc,
        output o_trace_seq,
        input  i_trace_rdy
    );

    modport slave (
        input  o_trace_vld,
        input  o_trace_ascii,
        input  o_trace_instrn,
        input  o_trace_pc,
        input  o_trace_seq,
        output i_trace_rdy
    );

endinterface : tt_ascii_instrn_trace_if

// File: rtl/tt_ascii_instrn_trace.sv
// ----------------------------------------------------------------------------
// tt_ascii_instrn_trace
//
// Purpose:
//   Multi-lane retire-trace buffer for simulation and debug logging. Up to
//   NUM_LANES retired instructions per cycle are decoded to a right-justified
//   ASCII mnemonic (RV32I, Zicsr, FENCE/ECALL/EBREAK, RV32M), tagged with PC
//   and a running sequence number, and written into a DEPTH-entry FIFO that
//   drains to a trace sink over a valid/ready handshake. The block only
//   observes the retire stage; it never affects architectural state.
//
// Parameters:
//   NUM_LANES  retire lanes per cycle (1..4)
//   DEPTH      FIFO entries, power of two, >= NUM_LANES and >= 2
//   XLEN       PC width
//   SEQ_W      sequence-number width
//
// Ports:
//   i_clk            clock
//   i_reset_n        asynchronous active-low reset
//   i_retire_vld     per-lane retire valid
//   i_retire_instrn  lane k instruction at [32k+31:32k]
//   i_retire_pc      lane k PC at [XLEN*k+XLEN-1:XLEN*k]
//   i_flush          synchronous flush of FIFO contents and drop statistics
//   trace_if         trace-sink handshake (master side)
//   o_fifo_cnt       occupied FIFO entries
//   o_drop_cnt       dropped-record count, saturating at 0xFFFF
//   o_overflow       sticky: at least one drop since reset/flush
//
// Behaviour summary:
//   - Valid lanes are handled in ascending lane index; the j-th valid lane
//     carries seq + j and seq advances by popcount(i_retire_vld) every cycle,
//     including during a flush and for lanes that get dropped.
//   - Free space is taken from the occupancy at the start of the cycle, so a
//     pop in the same cycle does not make room for a retire.
//   - The trace payload is read straight out of the head storage entry.
// ----------------------------------------------------------------------------
module tt_ascii_instrn_trace #(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 8,
    parameter int XLEN      = 32,
    parameter int SEQ_W     = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,

    input  logic [NUM_LANES-1:0]      i_retire_vld,
    input  logic [NUM_LANES*32-1:0]   i_retire_instrn,
    input  logic [NUM_LANES*XLEN-1:0] i_retire_pc,
    input  logic                      i_flush,

    tt_ascii_instrn_trace_if.master   trace_if,

    output logic [$clog2(DEPTH):0]    o_fifo_cnt,
    output logic [15:0]               o_drop_cnt,
    output logic                      o_overflow
);

    // ------------------------------------------------------------------------
    // Local sizes and types
    // ------------------------------------------------------------------------
    localparam int AW     = $clog2(DEPTH);          // storage index width
    localparam int PTR_W  = AW + 1;                 // pointer width (wrap bit)
    localparam int LCNT_W = $clog2(NUM_LANES + 1);  // counts 0..NUM_LANES

    typedef struct packed {
        logic [63:0]      ascii;
        logic [31:0]      instrn;
        logic [XLEN-1:0]  pc;
        logic [SEQ_W-1:0] seq;
    } rec_t;

    // RISC-V major opcodes recognised by the decoder.
    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    // ------------------------------------------------------------------------
    // Mnemonic decoder. String literals are sized to 64 bits, which zero-pads
    // on the left and gives the right-justified layout the sink expects.
    // ------------------------------------------------------------------------
    function automatic logic [63:0] decode_mnemonic(input logic [31:0] ins);
        logic [63:0] res;
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3  = ins[14:12];
        f7  = ins[31:25];
        res = 64'("ILLEG");
        if (ins[1:0] != 2'b11) begin
            res = 64'("RVC");
        end else begin
            case (ins[6:0])
                OPC_JAL:   res = 64'("JAL");
                OPC_JALR:  res = 64'("JALR");
                OPC_LUI:   res = 64'("LUI");
                OPC_AUIPC: res = 64'("AUIPC");
                OPC_BRANCH: begin
                    case (f3)
                        3'b000:  res = 64'("BEQ");
                        3'b001:  res = 64'("BNE");
                        3'b100:  res = 64'("BLT");
                        3'b101:  res = 64'("BGE");
                        3'b110:  res = 64'("BLTU");
                        3'b111:  res = 64'("BGEU");
                        default: res = 64'("ILLEG");
                    endcase
                end
                OPC_LOAD: begin
                    case (f3)
                        3'b000:  res = 64'("LB");
                        3'b001:  res = 64'("LH");
                        3'b010:  res = 64'("LW");
                        3'b100:  res = 64'("LBU");
                        3'b101:  res = 64'("LHU");
                        default: res = 64'("ILLEG");
                    endcase
                end
                OPC_STORE: begin
                    case (f3)
                        3'b000:  res = 64'("SB");
                        3'b001:  res = 64'("SH");
                        3'b010:  res = 64'("SW");
                        default: res = 64'("ILLEG");
                    endcase
                end
                OPC_OP_IMM: begin
                    case (f3)
                        3'b000:  res = 64'("ADDI");
                        3'b010:  res = 64'("SLTI");
                        3'b011:  res = 64'("SLTIU");
                        3'b100:  res = 64'("XORI");
                        3'b110:  res = 64'("ORI");
                        3'b111:  res = 64'("ANDI");
                        // Shifts reuse the top immediate bits as funct7.
                        3'b001:  res = (f7 == 7'b0000000) ? 64'("SLLI") : 64'("ILLEG");
                        3'b101: begin
                            if (f7 == 7'b0000000)      res = 64'("SRLI");
                            else if (f7 == 7'b0100000) res = 64'("SRAI");
                            else                       res = 64'("ILLEG");
                        end
                        default: res = 64'("ILLEG");
                    endcase
                end
                OPC_OP: begin
                    case (f7)
                        7'b0000000: begin
                            case (f3)
                                3'b000:  res = 64'("ADD");
                                3'b001:  res = 64'("SLL");
                                3'b010:  res = 64'("SLT");
                                3'b011:  res = 64'("SLTU");
                                3'b100:  res = 64'("XOR");
                                3'b101:  res = 64'("SRL");
                                3'b110:  res = 64'("OR");
                                default: res = 64'("AND");
                            endcase
                        end
                        7'b0100000: begin
                            case (f3)
                                3'b000:  res = 64'("SUB");
                                3'b101:  res = 64'("SRA");
                                default: res = 64'("ILLEG");
                            endcase
                        end
                        7'b0000001: begin
                            case (f3)
                                3'b000:  res = 64'("MUL");
                                3'b001:  res = 64'("MULH");
                                3'b010:  res = 64'("MULHSU");
                                3'b011:  res = 64'("MULHU");
                                3'b100:  res = 64'("DIV");
                                3'b101:  res = 64'("DIVU");
                                3'b110:  res = 64'("REM");
                                default: res = 64'("REMU");
                            endcase
                        end
                        default: res = 64'("ILLEG");
                    endcase
                end
                OPC_MISC_MEM: res = (f3 == 3'b000) ? 64'("FENCE") : 64'("ILLEG");
                OPC_SYSTEM: begin
                    case (f3)
                        3'b000: begin
                            // ECALL/EBREAK differ only in imm; all other
                            // fields must be zero.
                            if (ins[31:7] == 25'h0)         res = 64'("ECALL");
                            else if (ins[31:7] == 25'h2000) res = 64'("EBREAK");
                            else                            res = 64'("ILLEG");
                        end
                        3'b001:  res = 64'("CSRRW");
                        3'b010:  res = 64'("CSRRS");
                        3'b011:  res = 64'("CSRRC");
                        3'b101:  res = 64'("CSRRWI");
                        3'b110:  res = 64'("CSRRSI");
                        3'b111:  res = 64'("CSRRCI");
                        default: res = 64'("ILLEG");
                    endcase
                end
                default: res = 64'("ILLEG");
            endcase
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    rec_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [15:0]      drop_q, drop_d;
    logic             ovf_q, ovf_d;

    // ------------------------------------------------------------------------
    // Combinational lane allocation and next-state
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0]  fifo_cnt;
    logic [PTR_W-1:0]  free_slots;
    logic              fifo_empty;
    logic              pop;
    logic [LCNT_W-1:0] vld_idx;     // running index of the current valid lane
    logic [LCNT_W-1:0] n_acc;
    logic [LCNT_W-1:0] n_drop;
    logic [16:0]       drop_sum;
    logic              lane_we   [NUM_LANES];
    logic [AW-1:0]     lane_addr [NUM_LANES];
    rec_t              lane_rec  [NUM_LANES];

    // Occupancy from pointer difference; the extra wrap bit distinguishes
    // full (MSBs differ, rest equal) from empty (pointers equal).
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign free_slots = PTR_W'(DEPTH) - fifo_cnt;
    assign pop        = !fifo_empty && trace_if.i_trace_rdy;

    always_comb begin
        // NOTE: vld_idx/n_acc/n_drop are accumulated across loop iterations,
        // so they are assigned with blocking '=' and given a value up front;
        // every other comb output also gets a default first so no latch forms.
        vld_idx = '0;
        n_acc   = '0;
        n_drop  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_we[k]   = 1'b0;
            // Accepted lanes are always the lowest-indexed valid ones, so the
            // valid-lane index doubles as the write offset from wr_ptr.
            lane_addr[k] = wr_ptr_q[AW-1:0] + AW'(vld_idx);
            lane_rec[k]  = '{ascii:  decode_mnemonic(i_retire_instrn[32*k +: 32]),
                             instrn: i_retire_instrn[32*k +: 32],
                             pc:     i_retire_pc[XLEN*k +: XLEN],
                             seq:    seq_q + SEQ_W'(vld_idx)};
            if (i_retire_vld[k]) begin
                if (PTR_W'(vld_idx) < free_slots) begin
                    lane_we[k] = !i_flush;
                    n_acc      = n_acc + LCNT_W'(1);
                end else begin
                    n_drop     = n_drop + LCNT_W'(1);
                end
                vld_idx = vld_idx + LCNT_W'(1);
            end
        end

        drop_sum = {1'b0, drop_q} + 17'(n_drop);

        // Sequence numbers are consumed by every valid lane, flush or not.
        seq_d = seq_q + SEQ_W'(vld_idx);

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            drop_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(n_acc);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            ovf_d    = ovf_q || (n_drop != '0);
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: sequential state is updated with non-blocking '<=' so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Record storage
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: the storage is reset on purpose: the payload outputs come
        // straight from the head entry and must read zero while in reset.
        // A plain data FIFO would normally leave its array unreset.
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (lane_we[k]) begin
                    mem_q[lane_addr[k]] <= lane_rec[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: head entry drives the payload directly
    // ------------------------------------------------------------------------
    rec_t head;
    assign head = mem_q[rd_ptr_q[AW-1:0]];

    assign trace_if.o_trace_vld    = !fifo_empty;
    assign trace_if.o_trace_ascii  = head.ascii;
    assign trace_if.o_trace_instrn = head.instrn;
    assign trace_if.o_trace_pc     = head.pc;
    assign trace_if.o_trace_seq    = head.seq;

    assign o_fifo_cnt = fifo_cnt;
    assign o_drop_cnt = drop_q;
    assign o_overflow = ovf_q;

endmodule : tt_ascii_instrn_trace
